// File: rtl/bram_sdram_pkg.sv
// Shared types and address helpers for the block-RAM backed SDRAM responder.
package bram_sdram_pkg;

  localparam int unsigned SD_ADDR_W    = 23;
  localparam int unsigned IOCTL_ADDR_W = 20;
  localparam int unsigned DATA_W       = 32;

  // Sized for the largest legal LATENCY (8), i.e. $clog2(LATENCY+1) at its maximum
  localparam int unsigned LAT_CNT_W = $clog2(8 + 1);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACK     = 2'd1;
  localparam state_t ST_WAIT    = 2'd2;
  localparam state_t ST_REFRESH = 2'd3;

  typedef struct packed {
    logic [IOCTL_ADDR_W-3:0] word;
    logic [1:0]              lane;
  } ioctl_loc_t;

  // 16-bit-word request address to 32-bit word index (bit 0 dropped)
  function automatic logic [SD_ADDR_W-1:0] sd_word(input logic [SD_ADDR_W-1:0] a);
    return a >> 1;
  endfunction

  // Download byte address to word index and byte lane
  function automatic ioctl_loc_t ioctl_loc(input logic [IOCTL_ADDR_W-1:0] a);
    ioctl_loc_t l;
    l.word = a[IOCTL_ADDR_W-1:2];
    l.lane = a[1:0];
    return l;
  endfunction

endpackage

// File: rtl/bram_sdram_responder_bram_be.sv
// Single-port synchronous 32-bit RAM with byte enables and a registered read port.
module bram_be #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1 << AW) - 1];

  // Read only when no byte lane is written, so rdata holds across write-only cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (be == 4'b0000) rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/bram_sdram_responder.sv
// SDRAM-style request responder backed by on-chip RAM, with periodic refresh
// stalls and ioctl preload.
module bram_sdram_responder
  import bram_sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 14,
  parameter int unsigned LATENCY          = 2,
  parameter int unsigned REFRESH_INTERVAL = 750,
  parameter int unsigned REFRESH_CYCLES   = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SD_ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]       data,
  input  logic                    we,
  input  logic                    req,
  output logic                    ack,
  output logic                    valid,
  output logic [DATA_W-1:0]       q,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_data,
  input  logic                    ioctl_wr,
  input  logic                    ioctl_download
);

  localparam bit          REF_EN  = (REFRESH_INTERVAL > 0);
  localparam int unsigned REF_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned REF_LAST = (REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0;
  localparam int unsigned RC_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned RC_LAST = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;

  state_t                state, state_d;
  logic                  ack_d, valid_d;
  logic [DATA_W-1:0]     q_d;
  logic [LAT_CNT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [RC_W-1:0]       rcnt, rcnt_d;
  logic                  we_q, we_d;
  logic [REF_W-1:0]      ref_cnt, ref_cnt_d;
  logic                  ref_pend, ref_pend_d;
  logic                  ref_wrap_c, take_c, accept_c, ioctl_wr_c;

  ioctl_loc_t            loc_c;
  logic                  ram_en_c;
  logic [3:0]            ram_be_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_W-1:0]     ram_wdata_c, ram_rdata;

  assign take_c     = (state == ST_IDLE) && ref_pend;
  assign accept_c   = (state == ST_IDLE) && !ref_pend && req && !ioctl_download;
  assign ioctl_wr_c = ioctl_download && ioctl_wr;
  assign loc_c      = ioctl_loc(ioctl_addr);

  // RAM is accessed on the accept edge so the read word is already registered during ACK;
  // accept requires download low, so it never collides with a preload byte.
  always_comb begin
    ram_en_c    = ioctl_wr_c || accept_c;
    ram_be_c    = 4'b0000;
    ram_addr_c  = ADDR_WIDTH'(sd_word(addr));
    ram_wdata_c = data;
    if (ioctl_wr_c) begin
      ram_be_c    = 4'b0001 << loc_c.lane;
      ram_addr_c  = ADDR_WIDTH'(loc_c.word);
      ram_wdata_c = {4{ioctl_data}};
    end else if (accept_c && we) begin
      ram_be_c = 4'b1111;
    end
  end

  bram_be #(.AW(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (ram_en_c),
    .be    (ram_be_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // Free-running refresh timer; pending saturates at one
  always_comb begin
    ref_wrap_c = 1'b0;
    ref_cnt_d  = '0;
    if (REF_EN) begin
      ref_wrap_c = (ref_cnt == REF_W'(REF_LAST));
      ref_cnt_d  = ref_wrap_c ? '0 : ref_cnt + REF_W'(1);
    end
    ref_pend_d = (ref_pend && !take_c) || ref_wrap_c;
  end

  always_comb begin
    state_d   = state;
    ack_d     = 1'b0;
    valid_d   = 1'b0;
    q_d       = q;
    lat_cnt_d = lat_cnt;
    rcnt_d    = rcnt;
    we_d      = we_q;
    case (state)
      ST_IDLE: begin
        if (take_c) begin
          state_d = ST_REFRESH;
          rcnt_d  = '0;
        end else if (accept_c) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          we_d    = we;
        end
      end
      ST_ACK: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_CNT_W'(1);
          if (LATENCY == 1) begin
            valid_d = 1'b1;
            q_d     = ram_rdata;
          end
        end
      end
      ST_WAIT: begin
        // valid rides in the last WAIT cycle; the following cycle returns to IDLE
        if (lat_cnt == LAT_CNT_W'(LATENCY)) begin
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt + LAT_CNT_W'(1);
          if (lat_cnt == LAT_CNT_W'(LATENCY - 1)) begin
            valid_d = 1'b1;
            q_d     = ram_rdata;
          end
        end
      end
      default: begin
        if (rcnt == RC_W'(RC_LAST)) state_d = ST_IDLE;
        else                        rcnt_d  = rcnt + RC_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ack      <= 1'b0;
      valid    <= 1'b0;
      q        <= '0;
      lat_cnt  <= '0;
      rcnt     <= '0;
      we_q     <= 1'b0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      state    <= state_d;
      ack      <= ack_d;
      valid    <= valid_d;
      q        <= q_d;
      lat_cnt  <= lat_cnt_d;
      rcnt     <= rcnt_d;
      we_q     <= we_d;
      ref_cnt  <= ref_cnt_d;
      ref_pend <= ref_pend_d;
    end
  end

endmodule

// File: tb/tb_bram_sdram_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_bram_sdram_responder;

  localparam int unsigned AW  = 14;
  localparam int unsigned LAT = 2;
  localparam int unsigned RI  = 8;
  localparam int unsigned RC  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] addr;
  logic [31:0] data;
  logic        we, req;
  logic        ack, valid;
  logic [31:0] q;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr, ioctl_download;

  always #5 clk = ~clk;

  bram_sdram_responder #(
    .ADDR_WIDTH(AW), .LATENCY(LAT), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .data(data), .we(we), .req(req),
    .ack(ack), .valid(valid), .q(q), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc;        // cycles since reset release; cycle 0 precedes the first edge
  int          idle_at;    // first cycle the responder is next free
  int          last_take;  // cycle of the last refresh taken (0 = none)
  logic [31:0] exp_q;
  logic [31:0] mem [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // A refresh is pending at an idle cycle t if a counter wrap (every RI cycles) landed after the last take
  task automatic predict(input int c, output int acc);
    int t;
    t   = idle_at;
    acc = -1;
    for (int g = 0; g < 5000; g++) begin
      if ((t / int'(RI)) > (last_take / int'(RI))) begin
        last_take = t;
        t += int'(RC) + 1;
      end else if (t >= c) begin
        acc = t;
        break;
      end else begin
        t++;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "/ack"}, 32'(ack), 32'(0));
      chk({tag, "/valid"}, 32'(valid), 32'(0));
      chk({tag, "/q"}, q, exp_q);
      tick();
    end
  endtask

  task automatic access(input bit w, input logic [22:0] a, input logic [31:0] d, input string tag);
    int acc, ack_c, val_c, done, widx;
    logic [31:0] rexp;
    req  = 1'b1;
    we   = w;
    addr = a;
    data = d;
    widx = int'(a[AW:1]);
    predict(cyc, acc);
    ack_c = acc + 1;
    val_c = w ? -1 : acc + 1 + int'(LAT);
    done  = w ? acc + 2 : acc + int'(LAT) + 2;
    rexp  = mem.exists(widx) ? mem[widx] : 32'h0;
    if (w) mem[widx] = d;
    for (int k = 0; k < 300 && cyc < done; k++) begin
      chk({tag, "/ack"}, 32'(ack), 32'(cyc == ack_c));
      chk({tag, "/valid"}, 32'(valid), 32'(cyc == val_c));
      if (cyc == val_c) exp_q = rexp;
      chk({tag, "/q"}, q, exp_q);
      if (cyc == ack_c) begin
        req  = 1'b0;
        we   = 1'($urandom);
        addr = 23'($urandom);
        data = $urandom;
      end
      tick();
    end
    if (cyc != done) chk({tag, "/timeout"}, 32'(cyc), 32'(done));
    idle_at = done;
  endtask

  task automatic preload(input logic [19:0] ba, input logic [7:0] b);
    int widx;
    logic [31:0] w;
    ioctl_addr = ba;
    ioctl_data = b;
    ioctl_wr   = 1'b1;
    widx = int'(ba[AW+1:2]);
    w = mem.exists(widx) ? mem[widx] : 32'h0;
    w[8*ba[1:0] +: 8] = b;
    mem[widx] = w;
    chk("preload/ack", 32'(ack), 32'(0));
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    cyc       = 0;
    idle_at   = 0;
    last_take = 0;
    exp_q     = 32'h0;
  endtask

  initial begin
    logic [7:0]  b4 [4];
    logic [22:0] ra;
    int acc, dfall;
    req = 1'b0; we = 1'b0; addr = '0; data = '0;
    ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("reset/ack", 32'(ack), 32'(0));
    chk("reset/valid", 32'(valid), 32'(0));
    chk("reset/q", q, 32'h0);
    #20;
    do_reset();

    // Preload word 0 with 11 22 33 44, words 1..63 random, and the top word
    ioctl_download = 1'b1;
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
    for (int i = 0; i < 4; i++) preload(20'(i), b4[i]);
    for (int i = 4; i < 256; i++) preload(20'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) preload(20'(32'hFFFC + i), 8'($urandom));
    ioctl_download = 1'b0;
    idle_cycles(2, "post_dl");

    // Stray ioctl_wr without download must not touch RAM
    ioctl_addr = 20'h0; ioctl_data = 8'hAA; ioctl_wr = 1'b1;
    idle_cycles(1, "stray_wr");
    ioctl_wr = 1'b0;

    access(1'b0, 23'h000000, 32'h0, "rd_w0");
    chk("rd_w0/value", exp_q, 32'h44332211);
    access(1'b1, 23'h000010, 32'hDEADBEEF, "wr_10");
    access(1'b0, 23'h000011, 32'h0, "rd_11");
    access(1'b0, 23'h7FFFFF, 32'h0, "rd_alias");

    // Request held while downloading is not accepted until download drops
    ioctl_download = 1'b1;
    req = 1'b1; we = 1'b0; addr = 23'h000004; data = '0;
    for (int k = 0; k < 6; k++) begin
      chk("dl_block/ack", 32'(ack), 32'(0));
      tick();
    end
    ioctl_download = 1'b0;
    dfall = cyc;
    access(1'b0, 23'h000004, 32'h0, "dl_release");
    chk("dl_release/after", 32'(idle_at), 32'(idle_at));
    if (dfall < 0) chk("dl_release/cyc", 32'(dfall), 32'(0));

    // Back-to-back writes, request re-presented the cycle the responder frees
    for (int i = 0; i < 8; i++) access(1'b1, 23'(2 * (40 + i)), $urandom, "b2b_wr");
    for (int i = 0; i < 8; i++) access(1'b0, 23'(2 * (40 + i) + 1), 32'h0, "b2b_rd");

    // Reset during WAIT abandons the read
    req = 1'b1; we = 1'b0; addr = 23'h000002;
    predict(cyc, acc);
    for (int k = 0; k < 100 && cyc < acc + 2; k++) begin
      if (cyc == acc + 1) begin
        chk("rst_mid/ack", 32'(ack), 32'(1));
        req = 1'b0;
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("rst_mid/ack0", 32'(ack), 32'(0));
    chk("rst_mid/valid0", 32'(valid), 32'(0));
    chk("rst_mid/q0", q, 32'h0);
    do_reset();
    idle_cycles(5, "rst_after");
    access(1'b0, 23'h000002, 32'h0, "rst_rd");

    // Random traffic in the preloaded window, random upper bits for aliasing
    for (int i = 0; i < 60; i++) begin
      int widx;
      widx = $urandom_range(0, 63);
      ra = 23'({8'($urandom), 14'(widx), 1'($urandom)});
      idle_cycles($urandom_range(0, 3), "rnd_gap");
      access(1'($urandom), ra, $urandom, "rnd");
    end
    idle_cycles(4, "tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
